// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles every bus signal that crosses the arbiter: the I-cache refill port,
// the D-cache refill/write-back port and the shared main-memory port.
//   IMEM_*  : I-cache block read request, address, returned block, stall
//   DMEM_*  : D-cache read/write request, address, write block, returned block, stall
//   MEM_*   : main-memory strobes, address, write block, read block, busy
// Modport "slave" is the arbiter's view of the bundle. It serves the two cache
// ports and drives the memory strobes. Modport "master" is the surrounding
// system's view: the caches plus the memory model.
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              IMEM_READ;
    logic [ADDR_W-1:0] IMEM_ADDR;
    logic [DATA_W-1:0] IMEM_READDATA;
    logic              IMEM_BUSYWAIT;

    logic              DMEM_READ;
    logic              DMEM_WRITE;
    logic [ADDR_W-1:0] DMEM_ADDR;
    logic [DATA_W-1:0] DMEM_WRITEDATA;
    logic [DATA_W-1:0] DMEM_READDATA;
    logic              DMEM_BUSYWAIT;

    logic              MEM_READ;
    logic              MEM_WRITE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WRITEDATA;
    logic [DATA_W-1:0] MEM_READDATA;
    logic              MEM_BUSYWAIT;

    modport slave (
        input  IMEM_READ, IMEM_ADDR,
        output IMEM_READDATA, IMEM_BUSYWAIT,
        input  DMEM_READ, DMEM_WRITE, DMEM_ADDR, DMEM_WRITEDATA,
        output DMEM_READDATA, DMEM_BUSYWAIT,
        output MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITEDATA,
        input  MEM_READDATA, MEM_BUSYWAIT
    );

    modport master (
        output IMEM_READ, IMEM_ADDR,
        input  IMEM_READDATA, IMEM_BUSYWAIT,
        output DMEM_READ, DMEM_WRITE, DMEM_ADDR, DMEM_WRITEDATA,
        input  DMEM_READDATA, DMEM_BUSYWAIT,
        input  MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITEDATA,
        output MEM_READDATA, MEM_BUSYWAIT
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one block-wide main memory between the I-cache and the D-cache.
// Requests are served one at a time. When both caches request together, the
// grant alternates between them (round robin). The arbiter latches each granted
// request, runs it against memory and hands read blocks back through registers.
//   CLK   : clock, all state changes on the rising edge
//   RESET : synchronous, active-low reset
//   bus   : mem_arbiter_if.slave, carrying the I-cache, D-cache and memory ports
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic         CLK,
    input  logic         RESET,
    mem_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        DONE_I,
        DONE_D
    } state_t;

    state_t            state_q,     state_d;
    logic              lastGrant_q, lastGrant_d;
    logic              isWrite_q,   isWrite_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic [DATA_W-1:0] iRdata_q,    iRdata_d;
    logic [DATA_W-1:0] dRdata_q,    dRdata_d;

    logic iReq;
    logic dReq;
    logic grantI;
    logic grantD;
    logic memRead;
    logic memWrite;

    // A D-cache request is either kind. When both kind lines are high, the
    // request is treated as a write-back.
    // On a tie, the client that was not granted last time wins.
    // lastGrant: 0 = I, 1 = D.
    assign iReq   = bus.IMEM_READ;
    assign dReq   = bus.DMEM_READ | bus.DMEM_WRITE;
    assign grantI = iReq & (~dReq | lastGrant_q);
    assign grantD = dReq & (~iReq | ~lastGrant_q);

    // Next-state and Moore strobe logic. A grant snapshots the request so that
    // the client may change its inputs, or withdraw, without disturbing the
    // memory transaction already under way. The DONE states give the served
    // client its one-cycle busywait release.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        isWrite_d   = isWrite_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        iRdata_d    = iRdata_q;
        dRdata_d    = dRdata_q;
        memRead     = 1'b0;
        memWrite    = 1'b0;

        case (state_q)
            IDLE: begin
                if (grantI) begin
                    addr_d      = bus.IMEM_ADDR;
                    isWrite_d   = 1'b0;
                    lastGrant_d = 1'b0;
                    state_d     = SERVE_I;
                end else if (grantD) begin
                    addr_d      = bus.DMEM_ADDR;
                    wdata_d     = bus.DMEM_WRITEDATA;
                    isWrite_d   = bus.DMEM_WRITE;
                    lastGrant_d = 1'b1;
                    state_d     = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                memRead  = ~isWrite_q;
                memWrite = isWrite_q;
                if (!bus.MEM_BUSYWAIT) begin
                    if (!isWrite_q) begin
                        if (state_q == SERVE_I) begin
                            iRdata_d = bus.MEM_READDATA;
                        end else begin
                            dRdata_d = bus.MEM_READDATA;
                        end
                    end
                    state_d = (state_q == SERVE_I) ? DONE_I : DONE_D;
                end
            end
            DONE_I, DONE_D: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset leaves lastGrant pointing at D so
    // that the I-cache wins the first tie after reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            isWrite_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            iRdata_q    <= '0;
            dRdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            isWrite_q   <= isWrite_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            iRdata_q    <= iRdata_d;
            dRdata_q    <= dRdata_d;
        end
    end

    // Client stalls drop only in that client's DONE cycle. In every other state
    // they follow the request line.
    assign bus.IMEM_BUSYWAIT = bus.IMEM_READ & (state_q != DONE_I);
    assign bus.DMEM_BUSYWAIT = (bus.DMEM_READ | bus.DMEM_WRITE) & (state_q != DONE_D);

    assign bus.IMEM_READDATA = iRdata_q;
    assign bus.DMEM_READDATA = dRdata_q;
    assign bus.MEM_READ      = memRead;
    assign bus.MEM_WRITE     = memWrite;
    assign bus.MEM_ADDR      = addr_q;
    assign bus.MEM_WRITEDATA = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Drives the arbiter with directed scenarios and a randomized two-client run.
// A block memory model with programmable latency answers the memory strobes.
// Expected behaviour comes from transaction-level bookkeeping kept in the bench.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;
    int cycle  = 0;

    // Memory model state
    logic [DW-1:0] memArr [logic [AW-1:0]];
    int            strobeCnt = 0;
    int            memLat    = 1;
    bit            randLat   = 1'b0;

    // Model of what each client's READDATA register should hold
    logic [DW-1:0] expI = '0;
    logic [DW-1:0] expD = '0;

    function automatic logic [DW-1:0] memValue(input logic [AW-1:0] a);
        if (memArr.exists(a)) return memArr[a];
        return {4{4'h5, a}};
    endfunction

    // Memory responder: busy for memLat cycles of strobe, then ready for one
    // cycle. Outside of that ready cycle, read data is random junk.
    task automatic memStep();
        if (bus.MEM_READ || bus.MEM_WRITE) begin
            strobeCnt++;
            if (strobeCnt == 1 && randLat) memLat = $urandom_range(1, 4);
            if (strobeCnt == memLat + 1) begin
                bus.MEM_BUSYWAIT = 1'b0;
                if (bus.MEM_WRITE) begin
                    memArr[bus.MEM_ADDR] = bus.MEM_WRITEDATA;
                    bus.MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
                end else begin
                    bus.MEM_READDATA = memValue(bus.MEM_ADDR);
                end
            end else begin
                bus.MEM_BUSYWAIT = 1'b1;
                bus.MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
            end
        end else begin
            strobeCnt = 0;
            bus.MEM_BUSYWAIT = 1'b1;
            bus.MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        cycle++;
        memStep();
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        bus.IMEM_READ = 1'b1;
        tick(); tick(); tick();
        checks++; if (bus.MEM_READ !== 1'b0) $display("[TB] FAIL reset_mem_read: got %b want 0", bus.MEM_READ); else passes++;
        checks++; if (bus.MEM_WRITE !== 1'b0) $display("[TB] FAIL reset_mem_write: got %b want 0", bus.MEM_WRITE); else passes++;
        checks++; if (bus.MEM_ADDR !== '0) $display("[TB] FAIL reset_mem_addr: got %h want 0", bus.MEM_ADDR); else passes++;
        checks++; if (bus.MEM_WRITEDATA !== '0) $display("[TB] FAIL reset_mem_wdata: got %h want 0", bus.MEM_WRITEDATA); else passes++;
        checks++; if (bus.IMEM_READDATA !== '0) $display("[TB] FAIL reset_i_rdata: got %h want 0", bus.IMEM_READDATA); else passes++;
        checks++; if (bus.DMEM_READDATA !== '0) $display("[TB] FAIL reset_d_rdata: got %h want 0", bus.DMEM_READDATA); else passes++;
        checks++; if (bus.IMEM_BUSYWAIT !== 1'b1) $display("[TB] FAIL reset_i_busywait: got %b want 1", bus.IMEM_BUSYWAIT); else passes++;
        checks++; if (bus.DMEM_BUSYWAIT !== 1'b0) $display("[TB] FAIL reset_d_busywait: got %b want 0", bus.DMEM_BUSYWAIT); else passes++;
        bus.IMEM_READ = 1'b0;
        RESET = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        int readCycles = 0;
        int firstRead  = -1;
        int writeSeen  = 0;
        int bwLowCount = 0;
        int bwLowAt    = -1;
        bit addrOk     = 1'b1;
        logic [DW-1:0] want = 128'hDEADBEEF_00000000_00000000_00000001;
        memArr[28'h0000010] = want;
        memLat  = 5;
        randLat = 1'b0;
        bus.IMEM_ADDR = 28'h0000010;
        bus.IMEM_READ = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (bus.MEM_READ) begin
                readCycles++;
                if (firstRead < 0) firstRead = k;
                if (bus.MEM_ADDR !== 28'h0000010) addrOk = 1'b0;
            end
            if (bus.MEM_WRITE) writeSeen++;
            if (bus.IMEM_READ && !bus.IMEM_BUSYWAIT) begin
                bwLowCount++;
                bwLowAt = k;
                checks++; if (bus.IMEM_READDATA !== want) $display("[TB] FAIL single_rdata: got %h want %h", bus.IMEM_READDATA, want); else passes++;
            end
            if (k == 8) bus.IMEM_READ = 1'b0;
        end
        checks++; if (readCycles !== 6) $display("[TB] FAIL single_read_cycles: got %0d want 6", readCycles); else passes++;
        checks++; if (firstRead !== 1) $display("[TB] FAIL single_first_strobe: got %0d want 1", firstRead); else passes++;
        checks++; if (writeSeen !== 0) $display("[TB] FAIL single_no_write: got %0d want 0", writeSeen); else passes++;
        checks++; if (addrOk !== 1'b1) $display("[TB] FAIL single_mem_addr: got bad want 0000010"); else passes++;
        checks++; if (bwLowCount !== 1) $display("[TB] FAIL single_bw_low_count: got %0d want 1", bwLowCount); else passes++;
        checks++; if (bwLowAt !== 7) $display("[TB] FAIL single_bw_low_cycle: got %0d want 7", bwLowAt); else passes++;
        expI = want;
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        memLat = 20;
        bus.DMEM_ADDR = 28'h0000055;
        bus.DMEM_READ = 1'b1;
        for (int k = 0; k < 5 && !seen; k++) begin
            tick();
            seen = bus.MEM_READ;
        end
        checks++; if (seen !== 1'b1) $display("[TB] FAIL rstmid_serve_start: got %b want 1", seen); else passes++;
        tick(); tick();
        RESET = 1'b0;
        tick();
        checks++; if (bus.MEM_READ !== 1'b0) $display("[TB] FAIL rstmid_mem_read: got %b want 0", bus.MEM_READ); else passes++;
        checks++; if (bus.MEM_WRITE !== 1'b0) $display("[TB] FAIL rstmid_mem_write: got %b want 0", bus.MEM_WRITE); else passes++;
        checks++; if (bus.MEM_ADDR !== '0) $display("[TB] FAIL rstmid_mem_addr: got %h want 0", bus.MEM_ADDR); else passes++;
        checks++; if (bus.IMEM_READDATA !== '0) $display("[TB] FAIL rstmid_i_rdata: got %h want 0", bus.IMEM_READDATA); else passes++;
        checks++; if (bus.DMEM_READDATA !== '0) $display("[TB] FAIL rstmid_d_rdata: got %h want 0", bus.DMEM_READDATA); else passes++;
        checks++; if (bus.DMEM_BUSYWAIT !== 1'b1) $display("[TB] FAIL rstmid_d_busywait: got %b want 1", bus.DMEM_BUSYWAIT); else passes++;
        tick();
        RESET = 1'b1;
        bus.DMEM_READ = 1'b0;
        tick(); tick();
        checks++; if ((bus.MEM_READ | bus.MEM_WRITE) !== 1'b0) $display("[TB] FAIL rstmid_no_regrant: got %b want 0", bus.MEM_READ | bus.MEM_WRITE); else passes++;
        expI = '0;
        expD = '0;
    endtask

    task automatic test_simultaneous();
        int order[$];
        int doneCount = 0;
        int doneAt    = -1;
        int gapBad    = 0;
        int doneBad   = 0;
        int rdBad     = 0;
        int served    = -1;
        bit prevStrobe = 1'b0;
        bit strobe;
        randLat = 1'b1;
        bus.IMEM_ADDR  = 28'h0000100;
        bus.DMEM_ADDR  = 28'h0000200;
        bus.DMEM_WRITE = 1'b0;
        bus.IMEM_READ  = 1'b1;
        bus.DMEM_READ  = 1'b1;
        for (int k = 0; k < 80 && doneCount < 4; k++) begin
            tick();
            strobe = bus.MEM_READ | bus.MEM_WRITE;
            if (strobe && !prevStrobe) begin
                served = (bus.MEM_ADDR === 28'h0000100) ? 0 : ((bus.MEM_ADDR === 28'h0000200) ? 1 : 2);
                order.push_back(served);
                if (doneAt >= 0 && (cycle - doneAt) != 2) gapBad++;
            end
            if (!strobe && prevStrobe) begin
                doneAt = cycle;
                doneCount++;
                if (bus.IMEM_BUSYWAIT !== (served != 0) || bus.DMEM_BUSYWAIT !== (served != 1)) doneBad++;
                if (served == 0 && bus.IMEM_READDATA !== memValue(28'h0000100)) rdBad++;
                if (served == 1 && bus.DMEM_READDATA !== memValue(28'h0000200)) rdBad++;
            end
            prevStrobe = strobe;
        end
        bus.IMEM_READ = 1'b0;
        bus.DMEM_READ = 1'b0;
        checks++; if (doneCount !== 4) $display("[TB] FAIL simul_done_count: got %0d want 4", doneCount); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ((order.size() > i ? order[i] : -1) !== (i % 2))
                $display("[TB] FAIL simul_order_%0d: got %0d want %0d", i, (order.size() > i ? order[i] : -1), i % 2);
            else passes++;
        end
        checks++; if (gapBad !== 0) $display("[TB] FAIL simul_idle_gap: got %0d bad gaps want 0", gapBad); else passes++;
        checks++; if (doneBad !== 0) $display("[TB] FAIL simul_done_busywait: got %0d bad want 0", doneBad); else passes++;
        checks++; if (rdBad !== 0) $display("[TB] FAIL simul_rdata: got %0d bad want 0", rdBad); else passes++;
        expI = memValue(28'h0000100);
        expD = memValue(28'h0000200);
        tick();
    endtask

    task automatic test_writeback_refill();
        logic [DW-1:0] wd = {4{32'h11111111}};
        logic [DW-1:0] want;
        int writeCycles = 0;
        int readCycles  = 0;
        int wrongKind   = 0;
        int bad         = 0;
        bit done        = 1'b0;
        randLat = 1'b0;
        memLat  = 3;
        bus.DMEM_ADDR      = 28'h0000ABC;
        bus.DMEM_WRITEDATA = wd;
        bus.DMEM_WRITE     = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            if (bus.MEM_WRITE) begin
                writeCycles++;
                if (bus.MEM_ADDR !== 28'h0000ABC || bus.MEM_WRITEDATA !== wd) bad++;
            end
            if (bus.MEM_READ) wrongKind++;
            if (!bus.DMEM_BUSYWAIT) begin
                done = 1'b1;
                checks++; if (bus.DMEM_READDATA !== expD) $display("[TB] FAIL wb_rdata_unchanged: got %h want %h", bus.DMEM_READDATA, expD); else passes++;
            end
        end
        checks++; if (done !== 1'b1) $display("[TB] FAIL wb_done: got %b want 1", done); else passes++;
        checks++; if (writeCycles !== 4) $display("[TB] FAIL wb_write_cycles: got %0d want 4", writeCycles); else passes++;
        checks++; if (wrongKind !== 0) $display("[TB] FAIL wb_no_read: got %0d want 0", wrongKind); else passes++;
        checks++; if (bad !== 0) $display("[TB] FAIL wb_addr_data: got %0d bad want 0", bad); else passes++;
        checks++; if (memValue(28'h0000ABC) !== wd) $display("[TB] FAIL wb_mem_content: got %h want %h", memValue(28'h0000ABC), wd); else passes++;

        want = memValue(28'h0000123);
        bus.DMEM_WRITE     = 1'b0;
        bus.DMEM_READ      = 1'b1;
        bus.DMEM_ADDR      = 28'h0000123;
        bus.DMEM_WRITEDATA = {$urandom, $urandom, $urandom, $urandom};
        done = 1'b0;
        bad = 0;
        wrongKind = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            if (bus.MEM_READ) begin
                readCycles++;
                if (bus.MEM_ADDR !== 28'h0000123) bad++;
            end
            if (bus.MEM_WRITE) wrongKind++;
            if (!bus.DMEM_BUSYWAIT) begin
                done = 1'b1;
                checks++; if (bus.DMEM_READDATA !== want) $display("[TB] FAIL refill_rdata: got %h want %h", bus.DMEM_READDATA, want); else passes++;
            end
        end
        bus.DMEM_READ = 1'b0;
        checks++; if (done !== 1'b1) $display("[TB] FAIL refill_done: got %b want 1", done); else passes++;
        checks++; if (readCycles !== 4) $display("[TB] FAIL refill_read_cycles: got %0d want 4", readCycles); else passes++;
        checks++; if (wrongKind !== 0 || bad !== 0) $display("[TB] FAIL refill_kind_addr: got %0d/%0d bad want 0/0", wrongKind, bad); else passes++;
        expD = want;
        tick();
    endtask

    task automatic test_illegal();
        logic [DW-1:0] wd = {$urandom, $urandom, $urandom, $urandom};
        int readCycles  = 0;
        int writeCycles = 0;
        bit done        = 1'b0;
        memLat = 2;
        bus.DMEM_ADDR      = 28'h0000077;
        bus.DMEM_WRITEDATA = wd;
        bus.DMEM_READ      = 1'b1;
        bus.DMEM_WRITE     = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            if (bus.MEM_READ) readCycles++;
            if (bus.MEM_WRITE) writeCycles++;
            if (!bus.DMEM_BUSYWAIT) begin
                done = 1'b1;
                checks++; if (bus.DMEM_READDATA !== expD) $display("[TB] FAIL illegal_rdata_unchanged: got %h want %h", bus.DMEM_READDATA, expD); else passes++;
            end
        end
        bus.DMEM_READ  = 1'b0;
        bus.DMEM_WRITE = 1'b0;
        checks++; if (readCycles !== 0) $display("[TB] FAIL illegal_no_read: got %0d want 0", readCycles); else passes++;
        checks++; if (writeCycles !== 3) $display("[TB] FAIL illegal_write_cycles: got %0d want 3", writeCycles); else passes++;
        checks++; if (memValue(28'h0000077) !== wd) $display("[TB] FAIL illegal_mem_content: got %h want %h", memValue(28'h0000077), wd); else passes++;
        tick();
    endtask

    task automatic test_withdraw();
        logic [DW-1:0] want = memValue(28'h0000300);
        int  strobeCycles = 0;
        int  addrBad      = 0;
        bit  seen         = 1'b0;
        memLat = 6;
        bus.IMEM_ADDR = 28'h0000300;
        bus.IMEM_READ = 1'b1;
        for (int k = 0; k < 5 && !seen; k++) begin
            tick();
            seen = bus.MEM_READ;
        end
        checks++; if (seen !== 1'b1) $display("[TB] FAIL withdraw_start: got %b want 1", seen); else passes++;
        strobeCycles = 1;
        bus.IMEM_ADDR = 28'h0000999;
        tick();
        if (bus.MEM_READ) strobeCycles++;
        checks++; if (bus.MEM_ADDR !== 28'h0000300) $display("[TB] FAIL withdraw_addr_latched: got %h want 0000300", bus.MEM_ADDR); else passes++;
        bus.IMEM_READ = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (bus.MEM_READ | bus.MEM_WRITE) begin
                strobeCycles++;
                if (bus.MEM_ADDR !== 28'h0000300) addrBad++;
            end
        end
        checks++; if (strobeCycles !== 7) $display("[TB] FAIL withdraw_strobe_cycles: got %0d want 7", strobeCycles); else passes++;
        checks++; if (addrBad !== 0) $display("[TB] FAIL withdraw_addr_hold: got %0d bad want 0", addrBad); else passes++;
        checks++; if (bus.IMEM_READDATA !== want) $display("[TB] FAIL withdraw_rdata: got %h want %h", bus.IMEM_READDATA, want); else passes++;
        expI = want;
    endtask

    task automatic test_random();
        bit iPend = 0, dPend = 0;
        bit prevI = 0, prevD = 0, prevDWr = 0;
        logic [AW-1:0] prevIAddr = '0, prevDAddr = '0;
        logic [DW-1:0] prevDWd = '0;
        int  lastWin = 0;
        int  curClient = -1;
        bit  curWr = 0;
        logic [DW-1:0] curRet = '0;
        int  compCycle = -10;
        int  lastFall  = -10;
        int  txns      = 0;
        bit  prevStrobe = 0;
        bit  strobe;
        bit  iJust, dJust;
        int  w;
        logic [AW-1:0] expAddr;
        bit  expWr;
        // The most recent grant before this run went to the I-cache
        // (the withdrawn read), so a first tie goes to D.
        randLat = 1'b1;
        lastWin = 0;
        for (int k = 0; k < 700; k++) begin
            if (k >= 600 && !iPend && !dPend) break;
            tick();
            iJust = 1'b0;
            dJust = 1'b0;
            strobe = bus.MEM_READ | bus.MEM_WRITE;
            checks++; if (bus.MEM_READ && bus.MEM_WRITE) $display("[TB] FAIL rand_exclusive: got both strobes want one"); else passes++;
            if (strobe && !prevStrobe) begin
                if (prevI && prevD) w = 1 - lastWin;
                else if (prevI) w = 0;
                else if (prevD) w = 1;
                else w = -1;
                expAddr = (w == 0) ? prevIAddr : prevDAddr;
                expWr   = (w == 1) && prevDWr;
                checks++;
                if (w < 0 || bus.MEM_ADDR !== expAddr || bus.MEM_WRITE !== expWr ||
                    (expWr && bus.MEM_WRITEDATA !== prevDWd) || (cycle - lastFall) < 2)
                    $display("[TB] FAIL rand_grant: got addr %h wr %b at cycle %0d want client %0d addr %h wr %b",
                             bus.MEM_ADDR, bus.MEM_WRITE, cycle, w, expAddr, expWr);
                else passes++;
                curClient = w;
                curWr     = expWr;
                if (w >= 0) lastWin = w;
            end
            if (strobe && !bus.MEM_BUSYWAIT) begin
                compCycle = cycle;
                curRet    = bus.MEM_READDATA;
            end
            if (!strobe && prevStrobe) lastFall = cycle;
            if (compCycle >= 0 && cycle == compCycle + 1) begin
                checks++;
                if ((curClient == 0 ? bus.IMEM_BUSYWAIT : bus.DMEM_BUSYWAIT) !== 1'b0)
                    $display("[TB] FAIL rand_done_missing: got busywait high want low for client %0d", curClient);
                else passes++;
            end
            if (iPend && !bus.IMEM_BUSYWAIT) begin
                checks++;
                if (curClient != 0 || cycle != compCycle + 1 || bus.IMEM_READDATA !== curRet)
                    $display("[TB] FAIL rand_i_done: got rdata %h at cycle %0d want %h at cycle %0d", bus.IMEM_READDATA, cycle, curRet, compCycle + 1);
                else passes++;
                expI = curRet;
                iPend = 1'b0;
                iJust = 1'b1;
                txns++;
                bus.IMEM_READ = 1'b0;
            end
            if (dPend && !bus.DMEM_BUSYWAIT) begin
                checks++;
                if (curClient != 1 || cycle != compCycle + 1 || bus.DMEM_READDATA !== (curWr ? expD : curRet))
                    $display("[TB] FAIL rand_d_done: got rdata %h at cycle %0d want %h at cycle %0d", bus.DMEM_READDATA, cycle, curWr ? expD : curRet, compCycle + 1);
                else passes++;
                if (!curWr) expD = curRet;
                dPend = 1'b0;
                dJust = 1'b1;
                txns++;
                bus.DMEM_READ  = 1'b0;
                bus.DMEM_WRITE = 1'b0;
            end
            if (k < 600 && !iPend && !iJust && $urandom_range(0, 2) == 0) begin
                iPend = 1'b1;
                bus.IMEM_ADDR = 28'h0001000 + 28'($urandom_range(0, 4095));
                bus.IMEM_READ = 1'b1;
            end
            if (k < 600 && !dPend && !dJust && $urandom_range(0, 2) == 0) begin
                dPend = 1'b1;
                bus.DMEM_ADDR      = 28'h0002000 + 28'($urandom_range(0, 4095));
                bus.DMEM_WRITEDATA = {$urandom, $urandom, $urandom, $urandom};
                bus.DMEM_WRITE     = 1'($urandom_range(0, 1));
                bus.DMEM_READ      = bus.DMEM_WRITE ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            prevI      = bus.IMEM_READ;
            prevD      = bus.DMEM_READ | bus.DMEM_WRITE;
            prevDWr    = bus.DMEM_WRITE;
            prevIAddr  = bus.IMEM_ADDR;
            prevDAddr  = bus.DMEM_ADDR;
            prevDWd    = bus.DMEM_WRITEDATA;
            prevStrobe = strobe;
        end
        checks++; if (iPend || dPend) $display("[TB] FAIL rand_drain: got pending i=%b d=%b want none", iPend, dPend); else passes++;
        checks++; if (txns < 20) $display("[TB] FAIL rand_txn_count: got %0d want >= 20", txns); else passes++;
    endtask

    initial begin
        RESET              = 1'b0;
        bus.IMEM_READ      = 1'b0;
        bus.IMEM_ADDR      = '0;
        bus.DMEM_READ      = 1'b0;
        bus.DMEM_WRITE     = 1'b0;
        bus.DMEM_ADDR      = '0;
        bus.DMEM_WRITEDATA = '0;
        bus.MEM_BUSYWAIT   = 1'b1;
        bus.MEM_READDATA   = '0;
        test_reset();
        test_single_read();
        test_reset_mid();
        test_simultaneous();
        test_writeback_refill();
        test_illegal();
        test_withdraw();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
